// File: rtl/mem_issue_queue_pkg.sv
// Shared types for the memory issue queue: micro-op layout and
// functional-unit / memory-access encodings.
package mem_issue_queue_pkg;

    localparam int unsigned PRF_SIZE = 64;
    localparam int unsigned PREG_W   = $clog2(PRF_SIZE);
    localparam int unsigned IMM_W    = 32;

    typedef enum logic [2:0] {
        FU_NONE = 3'd0,
        FU_ALU  = 3'd1,
        FU_MUL  = 3'd2,
        FU_MEM  = 3'd3,
        FU_BR   = 3'd4
    } fu_code_t;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_type_t;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_t;

    typedef struct packed {
        logic              valid;
        fu_code_t          fu_code;
        mem_type_t         mem_type;
        mem_size_t         mem_size;
        logic [IMM_W-1:0]  imm;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic              rs1_valid;
        logic              rs2_valid;
    } micro_op_t;

    // A dispatch lane belongs to this queue only if it is a live memory op.
    function automatic logic is_mem_candidate(micro_op_t u);
        return u.valid && (u.fu_code == FU_MEM);
    endfunction

endpackage

// File: rtl/mem_issue_queue_ptr_ctrl.sv
// Circular-buffer pointer control shared by the issue queues: head/tail
// pointers with a wrap bit, registered occupancy and free-slot check.
module iq_ptr_ctrl #(
    parameter  int unsigned DEPTH     = 8,
    parameter  int unsigned ENQ_WIDTH = 2,
    localparam int unsigned PTR_W     = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [PTR_W-1:0] enq_count,
    input  logic             deq,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [PTR_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             enq_ready
);

    localparam int unsigned IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_P     = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ENQ_WIDTH_P = PTR_W'(ENQ_WIDTH);

    logic [PTR_W-1:0] free_slots;

    // Pointer and occupancy registers; flush squashes like reset.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq);
            tail  <= tail + enq_count;
            count <= count + enq_count - PTR_W'(deq);
        end
    end

    // Status derived from registered state only, never from this cycle's dequeue.
    always_comb begin
        free_slots = DEPTH_P - count;
        enq_ready  = (free_slots >= ENQ_WIDTH_P);
        empty      = (head == tail);
        full       = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
    end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: buffers memory uops from dispatch, waits for
// source operands of the head entry and issues one uop at a time to the
// memory pipe, honouring its busy handshake.
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ENQ_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  micro_op_t             enq_uop [ENQ_WIDTH],
    output logic                  enq_ready,
    input  logic [PRF_SIZE-1:0]   prf_ready,
    input  logic                  mem_busy,
    output micro_op_t             issue_uop,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] n_enq;
    logic             do_issue;
    logic             guard;

    micro_op_t        entries [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] wr_en;
    micro_op_t        wr_data [DEPTH];
    logic [IDX_W-1:0] wr_slot;

    logic [IDX_W-1:0] head_idx;
    micro_op_t        head_uop;
    logic             rs1_ok;
    logic             rs2_ok;

    iq_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .ENQ_WIDTH (ENQ_WIDTH)
    ) u_ptr (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .enq_count (n_enq),
        .deq       (do_issue),
        .head      (head),
        .tail      (tail),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .enq_ready (enq_ready)
    );

    // Compact candidate lanes in lane order onto consecutive slots from tail.
    always_comb begin
        wr_en   = '0;
        n_enq   = '0;
        wr_slot = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr_data[i] = '0;
        end
        for (int unsigned lane = 0; lane < ENQ_WIDTH; lane++) begin
            if (enq_ready && !full && is_mem_candidate(enq_uop[lane])) begin
                wr_slot          = tail[IDX_W-1:0] + n_enq[IDX_W-1:0];
                wr_en[wr_slot]   = 1'b1;
                wr_data[wr_slot] = enq_uop[lane];
                n_enq            = n_enq + PTR_W'(1);
            end
        end
    end

    // Head entry operand readiness and the single-issue decision.
    always_comb begin
        head_idx = head[IDX_W-1:0];
        head_uop = entries[head_idx];
        rs1_ok   = !head_uop.rs1_valid || prf_ready[head_uop.prs1];
        rs2_ok   = !head_uop.rs2_valid || prf_ready[head_uop.prs2];
        do_issue = !flush && !empty && entry_valid[head_idx] && rs1_ok && rs2_ok
                   && !mem_busy && !guard;
    end

    // Entry payload storage; only meaningful where the matching valid bit is set.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                entries[i] <= wr_data[i];
            end
        end
    end

    // Entry valid bits: set on enqueue, cleared when the head issues or on squash.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            entry_valid <= '0;
        end else begin
            if (do_issue) begin
                entry_valid[head_idx] <= 1'b0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    entry_valid[i] <= 1'b1;
                end
            end
        end
    end

    // Issue register: valid pulses for one cycle, payload holds until the next issue;
    // guard blocks the cycle after an issue, before the pipe can raise busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            issue_uop <= '0;
            guard     <= 1'b0;
        end else if (do_issue) begin
            issue_uop       <= head_uop;
            issue_uop.valid <= 1'b1;
            guard           <= 1'b1;
        end else begin
            issue_uop.valid <= 1'b0;
            guard           <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: a directed vector table,
// hand-written multi-cycle sequences and randomized traffic, all checked
// against a queue-based reference model of the issue rules.
module tb_mem_issue_queue;
    import mem_issue_queue_pkg::*;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned ENQ_WIDTH = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  flush;
    micro_op_t             enq_uop [ENQ_WIDTH];
    logic                  enq_ready;
    logic [PRF_SIZE-1:0]   prf_ready;
    logic                  mem_busy;
    micro_op_t             issue_uop;
    logic [$clog2(DEPTH):0] count;

    mem_issue_queue #(
        .DEPTH     (DEPTH),
        .ENQ_WIDTH (ENQ_WIDTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .enq_uop   (enq_uop),
        .enq_ready (enq_ready),
        .prf_ready (prf_ready),
        .mem_busy  (mem_busy),
        .issue_uop (issue_uop),
        .count     (count)
    );

    always #5 clock = ~clock;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model state: queued uops in program order, last issued uop, guard.
    micro_op_t mq[$];
    micro_op_t m_issue;
    bit        m_guard;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic micro_op_t mk(bit is_mem, mem_type_t t, logic [31:0] imm,
                                     logic [5:0] p1, logic [5:0] p2);
        micro_op_t u;
        u           = '0;
        u.valid     = 1'b1;
        u.fu_code   = is_mem ? FU_MEM : FU_ALU;
        u.mem_type  = t;
        u.mem_size  = MEM_W;
        u.imm       = imm;
        u.prs1      = p1;
        u.prs2      = p2;
        u.rs1_valid = 1'b1;
        u.rs2_valid = (t == MEM_STORE);
        return u;
    endfunction

    function automatic bit ops_ok(micro_op_t u);
        return (!u.rs1_valid || prf_ready[u.prs1]) && (!u.rs2_valid || prf_ready[u.prs2]);
    endfunction

    task automatic idle_lanes();
        for (int l = 0; l < ENQ_WIDTH; l++) enq_uop[l] = '0;
    endtask

    // Advance one clock: update the model from the inputs in force, then compare.
    task automatic step();
        bit rdy;
        bit iss;
        if (reset) begin
            mq.delete();
            m_guard = 0;
            m_issue = '0;
        end else if (flush) begin
            mq.delete();
            m_guard       = 0;
            m_issue.valid = 1'b0;
        end else begin
            rdy = (DEPTH - mq.size()) >= ENQ_WIDTH;
            iss = (mq.size() > 0) && ops_ok(mq[0]) && !mem_busy && !m_guard;
            if (iss) begin
                m_issue       = mq.pop_front();
                m_issue.valid = 1'b1;
                m_guard       = 1;
            end else begin
                m_issue.valid = 1'b0;
                m_guard       = 0;
            end
            if (rdy) begin
                for (int l = 0; l < ENQ_WIDTH; l++) begin
                    if (enq_uop[l].valid && enq_uop[l].fu_code == FU_MEM) mq.push_back(enq_uop[l]);
                end
            end
        end
        @(posedge clock);
        #1;
        check("count", 64'(count), 64'(mq.size()));
        check("enq_ready", 64'(enq_ready), 64'((DEPTH - mq.size()) >= ENQ_WIDTH));
        check("issue_uop", 64'(issue_uop), 64'(m_issue));
    endtask

    typedef struct {
        bit          rst;
        bit          fl;
        bit          busy;
        bit [1:0]    lanes;
        logic [31:0] imm;
        int unsigned exp_count;
        bit          exp_valid;
        logic [31:0] exp_imm;
        bit          exp_ready;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        mem_busy  = 1'b0;
        prf_ready = '1;
        idle_lanes();
        m_issue   = '0;
        m_guard   = 0;

        // rst fl busy lanes imm | count valid imm ready
        tbl[0] = '{1, 0, 0, 2'b00,   0, 0, 0,   0, 1};
        tbl[1] = '{0, 0, 0, 2'b01, 100, 1, 0,   0, 1};
        tbl[2] = '{0, 0, 0, 2'b00,   0, 0, 1, 100, 1};
        tbl[3] = '{0, 0, 0, 2'b00,   0, 0, 0,   0, 1};
        tbl[4] = '{0, 0, 0, 2'b11, 200, 2, 0,   0, 1};
        tbl[5] = '{0, 0, 0, 2'b10, 201, 2, 1, 200, 1};
        tbl[6] = '{0, 1, 0, 2'b11, 300, 0, 0,   0, 1};
        tbl[7] = '{0, 0, 0, 2'b00,   0, 0, 0,   0, 1};
        tbl[8] = '{0, 0, 0, 2'b00,   0, 0, 0,   0, 1};

        for (int v = 0; v < 9; v++) begin
            reset    = tbl[v].rst;
            flush    = tbl[v].fl;
            mem_busy = tbl[v].busy;
            idle_lanes();
            for (int l = 0; l < ENQ_WIDTH; l++) begin
                if (tbl[v].lanes[l]) enq_uop[l] = mk(1, MEM_LOAD, tbl[v].imm + 32'(l), 6'd5, 6'd0);
            end
            step();
            check("tbl_count", 64'(count), 64'(tbl[v].exp_count));
            check("tbl_valid", 64'(issue_uop.valid), 64'(tbl[v].exp_valid));
            check("tbl_ready", 64'(enq_ready), 64'(tbl[v].exp_ready));
            if (tbl[v].exp_valid) check("tbl_imm", 64'(issue_uop.imm), 64'(tbl[v].exp_imm));
        end
        reset = 1'b0;
        flush = 1'b0;
        idle_lanes();

        // Busy window: payload of the first load holds while the pipe is busy.
        enq_uop[0] = mk(1, MEM_LOAD, 32'd10, 6'd5, 6'd0);
        enq_uop[1] = mk(1, MEM_LOAD, 32'd11, 6'd5, 6'd0);
        step();
        idle_lanes();
        step();
        check("busy_first_valid", 64'(issue_uop.valid), 64'd1);
        check("busy_first_imm", 64'(issue_uop.imm), 64'd10);
        mem_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("busy_hold_valid", 64'(issue_uop.valid), 64'd0);
            check("busy_hold_imm", 64'(issue_uop.imm), 64'd10);
        end
        mem_busy = 1'b0;
        step();
        check("busy_second_valid", 64'(issue_uop.valid), 64'd1);
        check("busy_second_imm", 64'(issue_uop.imm), 64'd11);
        step();

        // Store blocked on prs2 stalls the load behind it.
        prf_ready[9] = 1'b0;
        enq_uop[0] = mk(1, MEM_STORE, 32'd50, 6'd1, 6'd9);
        enq_uop[1] = mk(1, MEM_LOAD, 32'd51, 6'd5, 6'd0);
        step();
        idle_lanes();
        for (int k = 0; k < 4; k++) begin
            step();
            check("store_blocked", 64'(issue_uop.valid), 64'd0);
        end
        prf_ready[9] = 1'b1;
        step();
        check("store_first", 64'({issue_uop.valid, issue_uop.imm}), 64'({1'b1, 32'd50}));
        step();
        step();
        check("load_after_store", 64'({issue_uop.valid, issue_uop.imm}), 64'({1'b1, 32'd51}));
        step();

        // Fill to 7 entries, confirm back-pressure, then drain one to reopen.
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            enq_uop[0] = mk(1, MEM_LOAD, 32'(60 + 2 * k), 6'd5, 6'd0);
            enq_uop[1] = mk(1, MEM_LOAD, 32'(61 + 2 * k), 6'd5, 6'd0);
            step();
        end
        idle_lanes();
        enq_uop[0] = mk(1, MEM_LOAD, 32'd66, 6'd5, 6'd0);
        step();
        check("fill_count", 64'(count), 64'd7);
        check("fill_not_ready", 64'(enq_ready), 64'd0);
        enq_uop[0] = mk(1, MEM_LOAD, 32'd90, 6'd5, 6'd0);
        enq_uop[1] = mk(1, MEM_LOAD, 32'd91, 6'd5, 6'd0);
        step();
        check("full_drop_count", 64'(count), 64'd7);
        idle_lanes();
        mem_busy = 1'b0;
        step();
        check("drain_count", 64'(count), 64'd6);
        check("drain_ready", 64'(enq_ready), 64'd1);
        mem_busy   = 1'b1;
        enq_uop[0] = mk(0, MEM_LOAD, 32'd98, 6'd5, 6'd0);
        enq_uop[1] = mk(1, MEM_LOAD, 32'd99, 6'd5, 6'd0);
        step();
        check("lane1_only_count", 64'(count), 64'd7);
        idle_lanes();
        mem_busy = 1'b0;
        for (int k = 0; k < 40 && mq.size() > 0; k++) step();
        check("fill_drained", 64'(mq.size()), 64'd0);
        step();

        // Twenty enqueue/issue pairs walk the pointers around the ring twice.
        for (int i = 0; i < 20; i++) begin
            enq_uop[0] = mk(1, MEM_LOAD, 32'(i), 6'd5, 6'd0);
            step();
            idle_lanes();
            step();
            check("wrap_order", 64'({issue_uop.valid, issue_uop.imm}), 64'({1'b1, 32'(i)}));
            step();
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            mem_busy  = ($urandom_range(0, 3) == 0);
            prf_ready = {$urandom, $urandom} | {$urandom, $urandom};
            for (int l = 0; l < ENQ_WIDTH; l++) begin
                enq_uop[l] = mk($urandom_range(0, 3) != 0, mem_type_t'($urandom_range(0, 1)),
                                $urandom, 6'($urandom), 6'($urandom));
                enq_uop[l].valid    = ($urandom_range(0, 4) != 0);
                enq_uop[l].mem_size = mem_size_t'($urandom_range(0, 3));
            end
            step();
        end
        reset     = 1'b0;
        flush     = 1'b0;
        mem_busy  = 1'b0;
        prf_ready = '1;
        idle_lanes();
        for (int k = 0; k < 64 && mq.size() > 0; k++) step();
        check("random_drained", 64'(mq.size()), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
